// File: rtl/fir_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module   : fir_frame_capture
//  Purpose  : Collects one frame of FIR output samples into a 2^LOG2_N-entry
//             buffer (optionally in bit-reversed order), zero-pads the frame
//             to full length, and hands it to the FFT stage with a ready/ack
//             handshake and a registered read port.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             in_valid/in_data - sample strobe and opaque sample word
//             in_ready         - sample accepted this cycle (FILL only)
//             rd_addr/rd_data  - FFT-side read, one cycle latency
//             frame_ready      - complete frame held in the buffer
//             frame_ack        - consumer pulse: frame consumed
//             overflow         - sticky: sample offered while in_ready=0
//             frame_count      - completed frames, wraps at 2^16
//  Revision : 1.0 - initial release
// ============================================================================
module fir_frame_capture #(
  parameter int DATA_W      = 32,
  parameter int LOG2_N      = 10,
  parameter int NUM_SAMPLES = 1000,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [LOG2_N-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int              c_n           = 1 << LOG2_N;
  localparam logic [LOG2_N:0] c_last_sample = (LOG2_N+1)'(NUM_SAMPLES - 1);
  localparam logic [LOG2_N:0] c_last_addr   = (LOG2_N+1)'(c_n - 1);
  localparam bit              c_has_pad     = (NUM_SAMPLES < c_n);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PAD   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              r_state;
  logic [LOG2_N:0]     r_cnt;
  logic [DATA_W-1:0]   r_mem [0:c_n-1];

  logic                w_we;
  logic [LOG2_N-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2_N; k++) begin
      r[k] = v[LOG2_N-1-k];
    end
    return r;
  endfunction

  // Only the low LOG2_N bits of the counter form an address; the extra bit
  // keeps the counter from aliasing when the last pad index is reached.
  always_comb begin
    w_waddr = BIT_REVERSE ? bitrev(r_cnt[LOG2_N-1:0]) : r_cnt[LOG2_N-1:0];
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_FILL: begin
        w_we    = in_valid;
        w_wdata = in_data;
      end
      S_PAD: begin
        w_we    = 1'b1;
        w_wdata = '0;
      end
      default: begin
        w_we    = 1'b0;
        w_wdata = '0;
      end
    endcase
  end

  // Buffer RAM: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read port; a same-address write in this cycle is not seen
  // until the next read (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_mem[rd_addr];
    end
  end

  // Control FSM with registered handshake outputs. in_ready mirrors
  // (r_state == S_FILL) and is updated on every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      in_ready    <= 1'b1;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last_sample) begin
              in_ready <= 1'b0;
              if (c_has_pad) begin
                r_state <= S_PAD;
              end else begin
                r_state     <= S_READY;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_addr) begin
            r_state     <= S_READY;
            frame_ready <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end
        end
        S_READY: begin
          if (frame_ack) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            frame_ready <= 1'b0;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_FILL;
          r_cnt    <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fir_frame_capture
//  Purpose  : Self-checking bench for fir_frame_capture. One instance uses
//             default parameters, a second uses natural order with a full
//             1024-sample frame. Read responses are checked by a monitor
//             against expected words queued by the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_frame_capture;

  localparam int N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: defaults (bit-reversed, 1000 samples)
  logic        a_in_valid, a_in_ready, a_frame_ready, a_frame_ack, a_overflow;
  logic [31:0] a_in_data, a_rd_data;
  logic [9:0]  a_rd_addr;
  logic [15:0] a_frame_count;
  // Instance B: natural order, 1024 samples
  logic        b_in_valid, b_in_ready, b_frame_ready, b_frame_ack, b_overflow;
  logic [31:0] b_in_data, b_rd_data;
  logic [9:0]  b_rd_addr;
  logic [15:0] b_frame_count;

  fir_frame_capture dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .frame_ready(a_frame_ready), .frame_ack(a_frame_ack),
    .overflow(a_overflow), .frame_count(a_frame_count)
  );

  fir_frame_capture #(.DATA_W(32), .LOG2_N(10), .NUM_SAMPLES(1024), .BIT_REVERSE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .frame_ready(b_frame_ready), .frame_ack(b_frame_ack),
    .overflow(b_overflow), .frame_count(b_frame_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_a [N];
  logic [31:0] ref_b [N];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          addr_a_q[$];
  int          addr_b_q[$];
  logic        a_rd_req = 1'b0;
  logic        b_rd_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference address map: reverse the 10 bits of the index arithmetically.
  function automatic int bitrev10(input int x);
    int r = 0;
    int v = x;
    for (int k = 0; k < 10; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // kind 0: i, kind 1: 1.0f, kind 2: i+2000
  function automatic logic [31:0] sample(input int kind, input int i);
    if (kind == 0) return 32'(i);
    if (kind == 1) return 32'h3F80_0000;
    return 32'(i + 2000);
  endfunction

  // Frame content of instance A: samples at bit-reversed slots, rest zero.
  task automatic model_frame_a(input int kind);
    for (int i = 0; i < N; i++) begin
      ref_a[bitrev10(i)] = (i < 1000) ? sample(kind, i) : 32'h0;
    end
  endtask

  // Read monitors: a request issued before a rising edge is answered
  // just after that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (a_rd_req) begin
        #1;
        if (exp_a_q.size() == 0) begin
          check("rd_a_unexpected", 32'd1, 32'd0);
        end else begin
          check($sformatf("rd_a[%0d]", addr_a_q.pop_front()), a_rd_data, exp_a_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (b_rd_req) begin
        #1;
        if (exp_b_q.size() == 0) begin
          check("rd_b_unexpected", 32'd1, 32'd0);
        end else begin
          check($sformatf("rd_b[%0d]", addr_b_q.pop_front()), b_rd_data, exp_b_q.pop_front());
        end
      end
    end
  end

  task automatic read_a(input int addr);
    @(negedge clk);
    a_rd_addr = 10'(addr);
    a_rd_req  = 1'b1;
    exp_a_q.push_back(ref_a[addr]);
    addr_a_q.push_back(addr);
  endtask

  task automatic read_b(input int addr);
    @(negedge clk);
    b_rd_addr = 10'(addr);
    b_rd_req  = 1'b1;
    exp_b_q.push_back(ref_b[addr]);
    addr_b_q.push_back(addr);
  endtask

  task automatic drain_reads;
    @(negedge clk);
    a_rd_req = 1'b0;
    b_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_a_pending", 32'(exp_a_q.size()), 32'd0);
    check("rd_b_pending", 32'(exp_b_q.size()), 32'd0);
  endtask

  // gap_mode 0: back-to-back, 1: every 3rd cycle, 2: random idle cycles
  task automatic stream_a(input int n, input int kind, input int gap_mode);
    int gaps;
    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (gaps > 0) begin
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (gaps - 1) @(negedge clk);
      end
      @(negedge clk);
      if (!a_in_ready) check($sformatf("a_in_ready_fill[%0d]", i), 32'(a_in_ready), 32'd1);
      a_in_valid = 1'b1;
      a_in_data  = sample(kind, i);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = $urandom;
  endtask

  // Called at the negedge just after the last data write of a full frame.
  task automatic expect_pad_then_ready(input int pad_cycles, input int frames);
    int cyc;
    check("a_in_ready_after_last", 32'(a_in_ready), 32'd0);
    cyc = 0;
    while (!a_frame_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("a_pad_cycles", 32'(cyc), 32'(pad_cycles));
    check("a_frame_ready", 32'(a_frame_ready), 32'd1);
    check("a_in_ready_in_ready", 32'(a_in_ready), 32'd0);
    check("a_frame_count", 32'(a_frame_count), 32'(frames));
  endtask

  task automatic ack_a;
    @(negedge clk);
    a_frame_ack = 1'b1;
    @(negedge clk);
    a_frame_ack = 1'b0;
    check("a_frame_ready_after_ack", 32'(a_frame_ready), 32'd0);
    check("a_in_ready_after_ack", 32'(a_in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_rd_addr = '0; a_frame_ack = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_rd_addr = '0; b_frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_frame_ready", 32'(a_frame_ready), 32'd0);
    check("rst_overflow", 32'(a_overflow), 32'd0);
    check("rst_frame_count", 32'(a_frame_count), 32'd0);
    check("rst_rd_data", a_rd_data, 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // 1: full frame, back-to-back
    stream_a(1000, 0, 0);
    model_frame_a(0);
    expect_pad_then_ready(24, 1);
    read_a(0); read_a(512); read_a(927); read_a(95);
    for (int k = 0; k < 16; k++) read_a(int'($urandom_range(0, N - 1)));
    drain_reads();

    // 2: backpressure while the frame is held
    @(negedge clk);
    check("bp_in_ready", 32'(a_in_ready), 32'd0);
    a_in_valid = 1'b1;
    a_in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_overflow", 32'(a_overflow), 32'd1);
    repeat (5) @(negedge clk);
    check("bp_overflow_sticky", 32'(a_overflow), 32'd1);
    check("bp_frame_ready", 32'(a_frame_ready), 32'd1);
    for (int k = 0; k < N; k++) read_a(k);
    drain_reads();

    // 3: handshake then a second frame with random gaps
    ack_a();
    stream_a(1000, 1, 2);
    model_frame_a(1);
    expect_pad_then_ready(24, 2);
    read_a(512);
    for (int k = 0; k < 32; k++) read_a(int'($urandom_range(0, N - 1)));
    drain_reads();

    // 4: every-3rd-cycle input, same contents as frame 1
    ack_a();
    stream_a(1000, 0, 1);
    model_frame_a(0);
    expect_pad_then_ready(24, 3);
    for (int k = 0; k < N; k++) read_a(k);
    drain_reads();

    // 5: reset mid-frame, then a fresh frame
    ack_a();
    stream_a(500, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
    check("mid_rst_frame_count", 32'(a_frame_count), 32'd0);
    check("mid_rst_overflow", 32'(a_overflow), 32'd0);
    stream_a(1000, 2, 0);
    model_frame_a(2);
    expect_pad_then_ready(24, 1);
    check("s5_overflow", 32'(a_overflow), 32'd0);
    read_a(0); read_a(512);
    for (int k = 0; k < 32; k++) read_a(int'($urandom_range(0, N - 1)));
    drain_reads();

    // 6: natural order, full frame, ack pulses during FILL are ignored
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (!b_in_ready) check($sformatf("b_in_ready_fill[%0d]", i), 32'(b_in_ready), 32'd1);
      if (b_frame_ready) check($sformatf("b_early_ready[%0d]", i), 32'(b_frame_ready), 32'd0);
      b_in_valid  = 1'b1;
      b_in_data   = 32'(i);
      b_frame_ack = ($urandom_range(0, 3) == 0);
      ref_b[i]    = 32'(i);
    end
    @(negedge clk);
    b_in_valid  = 1'b0;
    b_frame_ack = 1'b0;
    check("b_frame_ready_no_pad", 32'(b_frame_ready), 32'd1);
    check("b_in_ready_ready", 32'(b_in_ready), 32'd0);
    check("b_frame_count", 32'(b_frame_count), 32'd1);
    check("b_overflow", 32'(b_overflow), 32'd0);
    read_b(1023); read_b(0);
    for (int k = 0; k < 32; k++) read_b(int'($urandom_range(0, N - 1)));
    drain_reads();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_frame_capture.md
Name: fir_frame_capture

Overview:
- Sits directly downstream of the FIR filter stage; consumes its 32-bit floating-point output samples one at a time via a valid strobe.
- Packs one frame of NUM_SAMPLES filtered samples into an internal 2^LOG2_N-entry buffer, in bit-reversed order when BIT_REVERSE=1.
- Zero-pads the frame to 2^LOG2_N entries.
- Presents the finished frame to the FFT stage through a registered read port and a ready/ack handshake.

Parameters:
DATA_W, 32, sample width (IEEE-754 single, treated as opaque bits)
LOG2_N, 10, log2 of buffer/frame length (N = 1024)
NUM_SAMPLES, 1000, real samples per frame; 1 <= NUM_SAMPLES <= N
BIT_REVERSE, 1, 1 = write address is bit-reversed sample index; 0 = natural order

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data holds a new filter output this cycle
in_data  in  DATA_W  filtered sample
in_ready  out  1  block accepts a sample this cycle
rd_addr  in  LOG2_N  FFT-side read address
rd_data  out  DATA_W  buffer word at rd_addr, registered
frame_ready  out  1  complete frame is held in the buffer
frame_ack  in  1  one-cycle pulse from the consumer: frame consumed
overflow  out  1  sticky: a sample was offered while in_ready=0
frame_count  out  16  number of completed frames, wraps at 2^16

Behaviour:
- Reset values:
  - state=FILL, cnt=0, frame_ready=0, overflow=0, rd_data=0, frame_count=0.
  - in_ready=1 in the first cycle after reset.
  - Buffer contents are not cleared.
- Address map: waddr = bitrev_LOG2_N(cnt) if BIT_REVERSE else cnt.
  - cnt is a LOG2_N+1-bit counter.
- State FILL:
  - in_ready=1.
  - On in_valid=1: mem[waddr] <= in_data, cnt <= cnt+1.
  - A write of index NUM_SAMPLES-1 moves the block to PAD if NUM_SAMPLES<N, else to READY.
  - Gaps in in_valid are allowed. No timing relation is required between samples.
- State PAD:
  - in_ready=0.
  - Writes zero (32'h0) to mem[waddr] every cycle, cnt++.
  - The write of index N-1 moves the block to READY.
  - Duration is exactly N-NUM_SAMPLES cycles.
- State READY:
  - in_ready=0, frame_ready=1. frame_ready asserts in the cycle after the final write (data or pad).
  - frame_count increments once, on entry to READY.
  - frame_ack=1 causes: next cycle frame_ready=0, in_ready=1, state=FILL, cnt=0.
- frame_ack outside READY is ignored.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in all states. Latency is 1 cycle.
  - Content is guaranteed only while frame_ready=1.
  - A read and a write to the same address in one cycle returns the old data.
- Overflow:
  - in_valid=1 with in_ready=0 sets overflow=1. The sample is dropped and the buffer is unchanged.
  - overflow clears only on rst.
- Reset mid-frame discards the partial frame and restarts at cnt=0. frame_count also resets.
- Buffer is single-port-write, single-port-read synchronous RAM (block-RAM inferable). No combinational path from in_data to rd_data.

Test Plan:
1. Full frame, defaults:
   - Stimulus: in_valid=1 for 1000 consecutive cycles, in_data=i for sample i.
   - Required: in_ready drops after sample 999; 24 pad cycles follow; frame_ready=1 at cycle 1025 after the first write; frame_count=1.
   - Reads (value one cycle after address): rd_addr=0 -> 0; rd_addr=512 -> 1; rd_addr=927 (bitrev 999) -> 999; rd_addr=95 (bitrev 1000) -> 32'h0.
2. Backpressure:
   - Stimulus: while frame_ready=1, drive in_valid=1 with in_data=32'hDEADBEEF.
   - Required: in_ready=0; overflow=1 next cycle and stays 1; re-reading all 1024 addresses shows no change.
3. Handshake:
   - Stimulus: pulse frame_ack in READY, then stream 1000 samples with in_data=32'h3F800000.
   - Required: frame_ready=0 and in_ready=1 the cycle after ack; second frame completes with frame_count=2; rd_addr=512 -> 32'h3F800000.
4. Gapped input:
   - Stimulus: in_valid asserted every 3rd cycle, in_data=i.
   - Required: buffer contents are identical to scenario 1; frame_ready rises 24 cycles after the 1000th accepted sample.
5. Reset mid-frame:
   - Stimulus: assert rst for 1 cycle after 500 samples, then stream 1000 samples with in_data=i+2000.
   - Required: overflow=0, frame_count=1 at completion; rd_addr=0 -> 2000; rd_addr=512 -> 2001.
6. Natural order and ack outside READY:
   - Stimulus: BIT_REVERSE=0, NUM_SAMPLES=1024, in_data=i; drive frame_ack during FILL.
   - Required: frame_ack during FILL has no effect; no PAD cycles; frame_ready the cycle after the last write; rd_addr=1023 -> 1023.
